// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SRAM readers: default geometry
// and the feeder FSM state type.
package me_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefRows  = 16;
  localparam int unsigned DefAddrW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } me_state_e;

endpackage

// File: rtl/me_valid_pipe.sv
// Fixed-depth 1-bit strobe delay that tracks SRAM read latency, so the data
// return can be qualified without tagging each request.
module me_valid_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o
);

  logic [Depth-1:0] pipe_q;
  logic [Depth-1:0] pipe_d;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = valid_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_o = pipe_q[Depth-1];

endmodule

// File: rtl/cur_block_feeder.sv
// Streams one current block from SRAM to the ME delay/align stage and marks
// the ping-pong bank being loaded as not read-only for the duration.
module cur_block_feeder
  import me_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ROWS   = DefRows,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] blk_base_i,
  input  logic              bank_sel_i,
  input  logic              pause_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] cur0_o,
  output logic              cur0_valid_o,
  output logic              only_read0_o,
  output logic              only_read1_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned   CntW    = $clog2(ROWS) + 1;
  localparam logic [CntW-1:0] RowsCnt = CntW'(ROWS);

  me_state_e         state_q;
  logic [CntW-1:0]   issued_q;
  logic [CntW-1:0]   emitted_q;
  logic [ADDR_W-1:0] base_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] cur0_q;
  logic              valid_q;
  logic [1:0]        only_rd_q;
  logic              busy_q;
  logic              done_q;
  logic              ret_tap;

  // Data return strobe aligned with mem_rdata_i.
  me_valid_pipe #(
    .Depth(RD_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .valid_i(rd_en_q),
    .valid_o(ret_tap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      issued_q  <= '0;
      emitted_q <= '0;
      base_q    <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      cur0_q    <= '0;
      valid_q   <= 1'b0;
      only_rd_q <= 2'b11;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= ret_tap;
      if (ret_tap) begin
        cur0_q    <= mem_rdata_i;
        emitted_q <= emitted_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q               <= StFetch;
            base_q                <= blk_base_i;
            busy_q                <= 1'b1;
            only_rd_q[bank_sel_i] <= 1'b0;
            emitted_q             <= '0;
            issued_q              <= '0;
            // The first read goes out on the accept edge to keep latency minimal.
            if (!pause_i) begin
              rd_en_q  <= 1'b1;
              addr_q   <= blk_base_i;
              issued_q <= CntW'(1);
            end
          end
        end
        StFetch: begin
          if (issued_q == RowsCnt) begin
            state_q <= StDrain;
          end else if (!pause_i) begin
            rd_en_q  <= 1'b1;
            addr_q   <= base_q + ADDR_W'(issued_q);
            issued_q <= issued_q + 1'b1;
          end
        end
        StDrain: begin
          if (emitted_q == RowsCnt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          only_rd_q <= 2'b11;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd_en_o  = rd_en_q;
  assign mem_addr_o   = addr_q;
  assign cur0_o       = cur0_q;
  assign cur0_valid_o = valid_q;
  assign only_read0_o = only_rd_q[0];
  assign only_read1_o = only_rd_q[1];
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
